counter_seq: RTL and testbench
==============================

Name: counter_seq

Overview:
- Upstream controller for the loadable down-counter (`counter`, N-bit shared load/count bus).
- Owns the counter's bus direction (`we`) and load strobe (`trig`).
- Loads a programmed period, runs the count, and watches `out_pulse` (high when count==1).
- Re-arms for a programmed number of repetitions, then reports `done`.

Parameters:
- N, 3, width of the period and of the shared counter bus; must match the attached counter.
- REP_W, 4, width of the repetition count and of `pulse_cnt`.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  request a sequence; sampled in IDLE only.
- stop  input  1  abort; highest priority after reset.
- period  input  N  reload value, captured on accepted start.
- reps  input  REP_W  number of periods to run, captured on accepted start.
- cnt_bus  inout  N  to counter `out_or_load`; driven with period_r when we=0, Z when we=1.
- we  output  1  to counter `we`; 1 = counter drives bus and decrements.
- trig  output  1  to counter `trig`; load strobe.
- out_pulse  input  1  from counter; 1 when count==1.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse in DONE.
- err  output  1  one-cycle pulse on a rejected start (or a watchdog trip when enabled).
- pulse_cnt  output  REP_W  periods completed in the current sequence.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, we=0, trig=0, busy=0, done=0, err=0, pulse_cnt=0, period_r=0, reps_r=0.
- All outputs are registered.
- Bus drive: `cnt_bus` = period_r whenever we=0, Z otherwise. The counter drives the bus only when we=1, so there is never contention.

States:
- IDLE: we=0, trig=0, so the counter holds.
  - start=1 with period!=0 and reps!=0: capture period/reps, pulse_cnt<=0, go LOAD.
  - start=1 with period==0 or reps==0: err=1 for one cycle, stay IDLE.
- LOAD: we=0, trig=0 for exactly 1 cycle; guarantees the counter sees a 0->1 trig edge. Go TRIG.
- TRIG: we=0, trig=1 for exactly 1 cycle; the counter loads period_r at the end of this cycle. Go RUN.
- RUN: we=1, trig=0; the counter decrements once per cycle.
  - On out_pulse=1: pulse_cnt<=pulse_cnt+1.
  - If pulse_cnt+1==reps_r, go DONE; otherwise go LOAD.
- DONE: we=0, done=1 for 1 cycle, then IDLE.

Timing and boundaries:
- Latency: start at cycle t gives LOAD at t+1, TRIG at t+2, first RUN at t+3.
  - out_pulse arrives at RUN cycle t+2+P.
  - Each repetition costs P+2 cycles; done is asserted at t+1+reps*(P+2).
- period=1: out_pulse on the first RUN cycle.
- period=2^N-1: no wrap is possible (the counter stops at 0).
- reps=2^REP_W-1: pulse_cnt reaches the max without wrapping.
- stop=1 in any state: next state IDLE, we=0, trig=0, pulse_cnt holds, no done.
- stop and start together in IDLE: stop wins, start is ignored.
- start while busy: ignored.
- out_pulse outside RUN: ignored.
- Reset mid-sequence: immediate IDLE, all values as in reset.

Optional Feature:
- Macro: COUNTER_SEQ_WDOG_EN.
- Defined:
  - An (N+2)-bit watchdog counts RUN cycles; it clears on RUN entry and on out_pulse.
  - If it reaches 2^N+2 with no out_pulse: err=1 for one cycle, go IDLE (handles a stuck or disconnected counter).
- Undefined: no watchdog logic; RUN waits on out_pulse indefinitely.

Decomposition:
- Shared package counter_seq_pkg:
  - state encoding localparams S_IDLE=0, S_LOAD=1, S_TRIG=2, S_RUN=3, S_DONE=4, with a 3-bit state width constant.
  - WDOG_LIMIT expression.
- No sub-module is natural: FSM, capture registers and tristate are one block.
- Integration top counter_sys instantiates counter_seq plus counter with a shared N.

Test Plan:
- N=3, period=3, reps=2, start at cycle 0 -> LOAD c1, TRIG c2, bus 3,2,1 in c3-c5, out_pulse c5; LOAD c6, TRIG c7, out_pulse c10; done=1 in c11, pulse_cnt=2, busy=0 from c12.
- period=1, reps=1 -> out_pulse at c3, done at c4.
- start with period=0 (then with reps=0) -> err=1 for one cycle, busy stays 0, we=0, bus=0.
- period=7, reps=3, stop asserted at c6 -> IDLE at c7, we=0, pulse_cnt=0, no done; a new start at c10 runs normally.
- rst=0 at c4 of a period=5 run -> asynchronous return of all outputs to reset values; counter bus released to the controller (we=0).
- With COUNTER_SEQ_WDOG_EN, counter out_pulse tied to 0, period=7 -> err=1 exactly 10 cycles after RUN entry, then IDLE.

Source files
------------

// File: rtl/counter_seq_pkg.sv
// Shared definitions for the counter_seq controller: state encoding and watchdog limit.
package counter_seq_pkg;

  localparam int unsigned STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_TRIG = 3'd2,
    S_RUN  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  // A healthy counter pulses within 2^n RUN cycles; two cycles of slack on top.
  function automatic int unsigned wdog_limit(input int unsigned n);
    return (32'd1 << n) + 32'd2;
  endfunction

endpackage

// File: rtl/counter_seq_if.sv
// Control-side handshake of counter_seq: sequence request inputs and status outputs.
interface counter_seq_if #(
  parameter int N     = 3,
  parameter int REP_W = 4
);
  logic             start;
  logic             stop;
  logic [N-1:0]     period;
  logic [REP_W-1:0] reps;
  logic             busy;
  logic             done;
  logic             err;
  logic [REP_W-1:0] pulse_cnt;

  modport master (
    output start, stop, period, reps,
    input  busy, done, err, pulse_cnt
  );

  modport slave (
    input  start, stop, period, reps,
    output busy, done, err, pulse_cnt
  );
endinterface

// File: rtl/counter_seq.sv
// Sequencer for a loadable down-counter: load period, run, count pulses, repeat reps times.
// Optional stuck-counter watchdog in RUN: define COUNTER_SEQ_WDOG_EN.
module counter_seq
  import counter_seq_pkg::*;
#(
  parameter int N     = 3,
  parameter int REP_W = 4
) (
  input  logic         clk,
  input  logic         rst,
  counter_seq_if.slave ctl,
  inout  wire [N-1:0]  cnt_bus,
  output logic         we,
  output logic         trig,
  input  logic         out_pulse
);

  state_t           state_q, state_d;
  logic             we_q, we_d;
  logic             trig_q, trig_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [REP_W-1:0] pulse_cnt_q, pulse_cnt_d;
  logic [REP_W-1:0] pulse_nxt;
  logic [N-1:0]     period_q, period_d;
  logic [REP_W-1:0] reps_q, reps_d;

`ifdef COUNTER_SEQ_WDOG_EN
  localparam logic [N+1:0] WDOG_LIMIT = (N+2)'(wdog_limit(N));
  logic [N+1:0] wd_q, wd_d;
`endif

  // Counter owns the bus only while we=1, so the two drivers never overlap.
  assign cnt_bus = we_q ? 'z : period_q;

  always_comb begin
    state_d     = state_q;
    period_d    = period_q;
    reps_d      = reps_q;
    pulse_cnt_d = pulse_cnt_q;
    pulse_nxt   = pulse_cnt_q + REP_W'(1);
    err_d       = 1'b0;
`ifdef COUNTER_SEQ_WDOG_EN
    wd_d        = wd_q;
`endif
    if (ctl.stop) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (ctl.start) begin
            if (ctl.period != '0 && ctl.reps != '0) begin
              period_d    = ctl.period;
              reps_d      = ctl.reps;
              pulse_cnt_d = '0;
              state_d     = S_LOAD;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        S_LOAD: state_d = S_TRIG;
        S_TRIG: begin
          state_d = S_RUN;
`ifdef COUNTER_SEQ_WDOG_EN
          wd_d    = '0;
`endif
        end
        S_RUN: begin
          if (out_pulse) begin
            pulse_cnt_d = pulse_nxt;
            state_d     = (pulse_nxt == reps_q) ? S_DONE : S_LOAD;
`ifdef COUNTER_SEQ_WDOG_EN
            wd_d        = '0;
          end else if (wd_q + (N+2)'(1) == WDOG_LIMIT) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end else begin
            wd_d = wd_q + (N+2)'(1);
`endif
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end

    // Outputs are decoded from the next state so they register alongside it.
    we_d   = (state_d == S_RUN);
    trig_d = (state_d == S_TRIG);
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      we_q        <= 1'b0;
      trig_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      pulse_cnt_q <= '0;
      period_q    <= '0;
      reps_q      <= '0;
`ifdef COUNTER_SEQ_WDOG_EN
      wd_q        <= '0;
`endif
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      trig_q      <= trig_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      pulse_cnt_q <= pulse_cnt_d;
      period_q    <= period_d;
      reps_q      <= reps_d;
`ifdef COUNTER_SEQ_WDOG_EN
      wd_q        <= wd_d;
`endif
    end
  end

  assign we            = we_q;
  assign trig          = trig_q;
  assign ctl.busy      = busy_q;
  assign ctl.done      = done_q;
  assign ctl.err       = err_q;
  assign ctl.pulse_cnt = pulse_cnt_q;

endmodule

// File: tb/tb_counter_seq.sv
// Directed bench for counter_seq with a behavioural down-counter on the shared bus.
module tb_counter_seq;

  logic       clk = 1'b0;
  logic       rst;
  wire  [2:0] cnt_bus;
  logic       we, trig, out_pulse;
  logic [2:0] ctr_q;
  logic       trig_prev;
  logic       pulse_kill, pulse_force;
  int         n_checks = 0;
  int         n_fail   = 0;

  int we_e   [1:12] = '{0,0,1,1,1,0,0,1,1,1,0,0};
  int trig_e [1:12] = '{0,1,0,0,0,0,1,0,0,0,0,0};
  int busy_e [1:12] = '{1,1,1,1,1,1,1,1,1,1,1,0};
  int done_e [1:12] = '{0,0,0,0,0,0,0,0,0,0,1,0};
  int op_e   [1:12] = '{0,0,0,0,1,0,0,0,0,1,0,0};
  int pc_e   [1:12] = '{0,0,0,0,0,1,1,1,1,1,2,2};
  int bus_e  [1:12] = '{3,3,3,2,1,3,3,3,2,1,3,3};

  counter_seq_if #(.N(3), .REP_W(4)) ctl_if ();

  counter_seq #(.N(3), .REP_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .ctl       (ctl_if),
    .cnt_bus   (cnt_bus),
    .we        (we),
    .trig      (trig),
    .out_pulse (out_pulse)
  );

  always #5 clk = ~clk;

  // Down-counter: loads on a rising trig, decrements while we=1, stops at 0.
  assign cnt_bus   = we ? ctr_q : 3'bzzz;
  assign out_pulse = ((ctr_q == 3'd1) && !pulse_kill) || pulse_force;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctr_q     <= 3'd0;
      trig_prev <= 1'b0;
    end else begin
      trig_prev <= trig;
      if (trig && !trig_prev) ctr_q <= cnt_bus;
      else if (we && ctr_q != 3'd0) ctr_q <= ctr_q - 3'd1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_start(input logic [2:0] p, input logic [3:0] r);
    ctl_if.start  = 1'b1;
    ctl_if.period = p;
    ctl_if.reps   = r;
    step();
    ctl_if.start  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int first_op, done_cyc;
    rst = 1'b0;
    ctl_if.start = 1'b0; ctl_if.stop = 1'b0; ctl_if.period = '0; ctl_if.reps = '0;
    pulse_kill = 1'b0; pulse_force = 1'b0;
    #2;
    check("rst_busy", ctl_if.busy, 0);
    check("rst_we", we, 0);
    check("rst_trig", trig, 0);
    check("rst_done", ctl_if.done, 0);
    check("rst_err", ctl_if.err, 0);
    check("rst_pcnt", ctl_if.pulse_cnt, 0);
    check("rst_bus", cnt_bus, 0);
    step(); step();
    rst = 1'b1;
    step();

    // Rejected starts: period 0, then reps 0.
    run_start(3'd0, 4'd2);
    check("err_p0", ctl_if.err, 1);
    check("err_p0_busy", ctl_if.busy, 0);
    check("err_p0_we", we, 0);
    check("err_p0_bus", cnt_bus, 0);
    step();
    check("err_p0_clr", ctl_if.err, 0);
    run_start(3'd3, 4'd0);
    check("err_r0", ctl_if.err, 1);
    check("err_r0_busy", ctl_if.busy, 0);
    step();
    check("err_r0_clr", ctl_if.err, 0);
    check("err_r0_busy2", ctl_if.busy, 0);

    // period=3 reps=2, with a start while busy during c4.
    run_start(3'd3, 4'd2);
    for (int c = 1; c <= 12; c++) begin
      check($sformatf("t1_we_c%0d", c), we, we_e[c]);
      check($sformatf("t1_trig_c%0d", c), trig, trig_e[c]);
      check($sformatf("t1_busy_c%0d", c), ctl_if.busy, busy_e[c]);
      check($sformatf("t1_done_c%0d", c), ctl_if.done, done_e[c]);
      check($sformatf("t1_op_c%0d", c), out_pulse, op_e[c]);
      check($sformatf("t1_pcnt_c%0d", c), ctl_if.pulse_cnt, pc_e[c]);
      check($sformatf("t1_bus_c%0d", c), cnt_bus, bus_e[c]);
      if (c == 3) begin ctl_if.start = 1'b1; ctl_if.period = 3'd5; end
      if (c == 4) ctl_if.start = 1'b0;
      step();
    end

    // period=1 reps=1.
    run_start(3'd1, 4'd1);
    step(); step();
    check("p1_op_c3", out_pulse, 1);
    check("p1_we_c3", we, 1);
    step();
    check("p1_done_c4", ctl_if.done, 1);
    check("p1_pcnt_c4", ctl_if.pulse_cnt, 1);
    step();
    check("p1_busy_c5", ctl_if.busy, 0);

    // out_pulse forced during IDLE/LOAD/TRIG must not count.
    pulse_force = 1'b1;
    run_start(3'd2, 4'd1);
    step();
    check("ign_trig_c2", trig, 1);
    check("ign_pcnt_c2", ctl_if.pulse_cnt, 0);
    pulse_force = 1'b0;
    step(); step(); step();
    check("ign_done_c5", ctl_if.done, 1);
    check("ign_pcnt_c5", ctl_if.pulse_cnt, 1);
    step();

    // Stop mid-run, then a fresh start.
    run_start(3'd7, 4'd3);
    for (int c = 1; c < 6; c++) step();
    ctl_if.stop = 1'b1;
    step();
    ctl_if.stop = 1'b0;
    check("stop_busy_c7", ctl_if.busy, 0);
    check("stop_we_c7", we, 0);
    check("stop_trig_c7", trig, 0);
    check("stop_pcnt_c7", ctl_if.pulse_cnt, 0);
    check("stop_done_c7", ctl_if.done, 0);
    for (int c = 8; c <= 10; c++) begin
      step();
      check($sformatf("stop_done_c%0d", c), ctl_if.done, 0);
    end
    run_start(3'd2, 4'd1);
    step(); step(); step(); step();
    check("restart_done", ctl_if.done, 1);
    check("restart_pcnt", ctl_if.pulse_cnt, 1);
    step();

    // Stop and start together in IDLE: stop wins.
    ctl_if.stop = 1'b1;
    run_start(3'd3, 4'd1);
    ctl_if.stop = 1'b0;
    check("ss_busy", ctl_if.busy, 0);
    check("ss_err", ctl_if.err, 0);
    check("ss_bus", cnt_bus, 2);

    // Boundaries: period=7, reps=15.
    first_op = 0; done_cyc = 0;
    run_start(3'd7, 4'd15);
    for (int c = 1; c <= 200; c++) begin
      if (out_pulse && first_op == 0) first_op = c;
      if (ctl_if.done) begin
        done_cyc = c;
        check("max_pcnt", ctl_if.pulse_cnt, 15);
        break;
      end
      step();
    end
    check("max_first_op", first_op, 9);
    check("max_done_cyc", done_cyc, 136);
    step();
    check("max_busy_after", ctl_if.busy, 0);

    // Asynchronous reset mid-sequence.
    run_start(3'd5, 4'd1);
    step(); step(); step();
    check("ar_we_before", we, 1);
    rst = 1'b0;
    #2;
    check("ar_busy", ctl_if.busy, 0);
    check("ar_we", we, 0);
    check("ar_trig", trig, 0);
    check("ar_pcnt", ctl_if.pulse_cnt, 0);
    check("ar_bus", cnt_bus, 0);
    step();
    rst = 1'b1;
    step();

    // Counter never pulses.
    pulse_kill = 1'b1;
    run_start(3'd7, 4'd1);
`ifdef COUNTER_SEQ_WDOG_EN
    for (int c = 1; c <= 14; c++) begin
      if (c >= 3) check($sformatf("wd_err_c%0d", c), ctl_if.err, (c == 13) ? 1 : 0);
      if (c == 12) check("wd_busy_c12", ctl_if.busy, 1);
      if (c == 13) check("wd_busy_c13", ctl_if.busy, 0);
      step();
    end
`else
    for (int c = 1; c <= 22; c++) begin
      check($sformatf("hang_err_c%0d", c), ctl_if.err, 0);
      step();
    end
    check("hang_busy", ctl_if.busy, 1);
    check("hang_we", we, 1);
    ctl_if.stop = 1'b1;
    step();
    ctl_if.stop = 1'b0;
    check("hang_stop_busy", ctl_if.busy, 0);
`endif
    pulse_kill = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
